// File: rtl/sdram_block_copy_if.sv
// Avalon-MM bus between the block copier (master) and the SDRAM controller slave port.
interface sdram_block_copy_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32
);
  logic                  chipselect;
  logic [DATA_W/8-1:0]   byteenable;
  logic [ADDR_W-1:0]     address;
  logic                  read_n;
  logic                  write_n;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output chipselect, byteenable, address, read_n, write_n, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  chipselect, byteenable, address, read_n, write_n, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/sdram_block_copy.sv
// Pipelined SDRAM block copy / fill engine: reads stream through a small FIFO into writes.
//
// state   | meaning
// IDLE    | waiting for start; inputs latched on acceptance
// RUN     | issuing reads (copy) and writes, one command per accepted cycle
// DRAIN   | all writes accepted, waiting for any outstanding read to retire
// DONE    | done=1, held until start drops
module sdram_block_copy #(
  parameter int          DATA_W     = 16,
  parameter int          ADDR_W     = 32,
  parameter int          LEN_W      = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned DEF_SRC    = 600000,
  parameter int unsigned DEF_DST    = 650000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic [31:0]       toHexLed,
  sdram_block_copy_if.master avm
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]       DEPTH_V = FIFO_DEPTH[CW:0];
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t state_q, state_n;

  logic              mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [LEN_W-1:0]  reads_issued_q, writes_issued_q, words_done_q;
  logic [CW-1:0]     outstanding_q, fifo_count_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [ADDR_W-1:0] address_q;
  logic              read_n_q, write_n_q;
  logic [DATA_W-1:0] writedata_q;

  logic        cmd_pend, acc_rd, acc_wr, free, push, pop, last_wr;
  logic        start_acc, issue_rd, issue_wr;
  logic [CW:0] credit_used;

  assign cmd_pend    = !read_n_q || !write_n_q;
  assign acc_rd      = !read_n_q  && !avm.waitrequest;
  assign acc_wr      = !write_n_q && !avm.waitrequest;
  assign free        = !cmd_pend || !avm.waitrequest;
  // data returning while nothing is outstanding belongs to a transfer killed by reset
  assign push        = avm.readdatavalid && (outstanding_q != '0);
  assign pop         = issue_wr && !mode_q;
  assign last_wr     = acc_wr && ((words_done_q + LEN_W'(1)) == len_q);
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count_q} + {{CW{1'b0}}, acc_rd};

  always_comb begin
    state_n   = state_q;
    start_acc = 1'b0;
    issue_rd  = 1'b0;
    issue_wr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_n   = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_wr) begin
          state_n = mode_q ? S_DONE : S_DRAIN;
        end else if (free) begin
          if (mode_q)
            issue_wr = (writes_issued_q != len_q);
          else if (fifo_count_q != '0)
            issue_wr = 1'b1;
          else if ((reads_issued_q != len_q) && (credit_used < DEPTH_V))
            issue_rd = 1'b1;
        end
      end
      S_DRAIN: begin
        if (outstanding_q == '0) state_n = S_DONE;
      end
      S_DONE: begin
        if (!start) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      mode_q          <= 1'b0;
      fill_q          <= '0;
      len_q           <= '0;
      rd_addr_q       <= ADDR_W'(DEF_SRC);
      wr_addr_q       <= ADDR_W'(DEF_DST);
      reads_issued_q  <= '0;
      writes_issued_q <= '0;
      words_done_q    <= '0;
      outstanding_q   <= '0;
      fifo_count_q    <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      address_q       <= '0;
      read_n_q        <= 1'b1;
      write_n_q       <= 1'b1;
      writedata_q     <= '0;
    end else begin
      state_q <= state_n;

      if (start_acc) begin
        mode_q          <= mode;
        fill_q          <= fill_value;
        len_q           <= length;
        rd_addr_q       <= src_base;
        wr_addr_q       <= dst_base;
        reads_issued_q  <= '0;
        writes_issued_q <= '0;
        words_done_q    <= '0;
      end

      if (issue_rd) begin
        address_q      <= rd_addr_q;
        read_n_q       <= 1'b0;
        write_n_q      <= 1'b1;
        rd_addr_q      <= rd_addr_q + STEP;
        reads_issued_q <= reads_issued_q + LEN_W'(1);
      end else if (issue_wr) begin
        address_q       <= wr_addr_q;
        read_n_q        <= 1'b1;
        write_n_q       <= 1'b0;
        writedata_q     <= mode_q ? fill_q : fifo_mem[rd_ptr_q];
        wr_addr_q       <= wr_addr_q + STEP;
        writes_issued_q <= writes_issued_q + LEN_W'(1);
      end else if (free) begin
        read_n_q  <= 1'b1;
        write_n_q <= 1'b1;
      end

      if (acc_wr) words_done_q <= words_done_q + LEN_W'(1);

      outstanding_q <= outstanding_q + CW'(acc_rd) - CW'(push);
      fifo_count_q  <= fifo_count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= avm.readdata;
  end

  assign avm.chipselect = 1'b1;
  assign avm.byteenable = '1;
  assign avm.address    = address_q;
  assign avm.read_n     = read_n_q;
  assign avm.write_n    = write_n_q;
  assign avm.writedata  = writedata_q;

  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign words_done = words_done_q;
  assign toHexLed   = {16'(words_done_q), 4'(outstanding_q), 4'(fifo_count_q), 5'b0, state_q};
endmodule
